// File: rtl/wordle_guess_scorer_pkg.sv
// Shared definitions for the Wordle guess scorer: colour codes, FSM states and
// default word geometry.
package wordle_guess_scorer_pkg;

  localparam int DEF_LETTER_W    = 8;
  localparam int DEF_WORD_LEN    = 5;
  localparam int DEF_MAX_GUESSES = 6;

  localparam logic [1:0] COL_GRAY   = 2'b00;
  localparam logic [1:0] COL_YELLOW = 2'b01;
  localparam logic [1:0] COL_GREEN  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

endpackage

// File: rtl/wordle_guess_scorer.sv
// Scores one guess against the secret word (green pass, then exhaustive yellow
// pass), streams tile colours to the VGA tile store and tracks win/lose.
module wordle_guess_scorer
  import wordle_guess_scorer_pkg::*;
#(
  parameter int LETTER_W    = DEF_LETTER_W,
  parameter int WORD_LEN    = DEF_WORD_LEN,
  parameter int MAX_GUESSES = DEF_MAX_GUESSES
) (
  input  logic                         board_clk,
  input  logic                         reset,
  input  logic                         new_game,
  input  logic                         start,
  input  logic [WORD_LEN*LETTER_W-1:0] guess,
  input  logic [WORD_LEN*LETTER_W-1:0] secret,
  output logic                         busy,
  output logic                         done,
  output logic [2*WORD_LEN-1:0]        result,
  output logic [2:0]                   guess_num,
  output logic                         win,
  output logic                         lose,
  output logic                         wr_en,
  output logic [2:0]                   wr_row,
  output logic [2:0]                   wr_col,
  output logic [1:0]                   wr_color
);

  localparam int               WORD_W    = WORD_LEN * LETTER_W;
  localparam int               RES_W     = 2 * WORD_LEN;
  localparam logic [2:0]       LAST      = 3'(WORD_LEN - 1);
  localparam logic [2:0]       MAX_GN    = 3'(MAX_GUESSES);
  localparam logic [RES_W-1:0] ALL_GREEN = {WORD_LEN{COL_GREEN}};

  function automatic logic [LETTER_W-1:0] letter_at(input logic [WORD_W-1:0] w, input logic [2:0] idx);
    return w[LETTER_W*int'(idx) +: LETTER_W];
  endfunction

  function automatic logic [1:0] color_at(input logic [RES_W-1:0] r, input logic [2:0] idx);
    return r[2*int'(idx) +: 2];
  endfunction

  state_t                state_r, state_nx;
  logic [WORD_W-1:0]     g_r, g_nx, s_r, s_nx;
  logic [RES_W-1:0]      res_r, res_nx, result_r, result_nx;
  logic [WORD_LEN-1:0]   used_r, used_nx;
  logic [2:0]            i_r, i_nx, j_r, j_nx;
  logic [2:0]            guess_num_r, guess_num_nx;
  logic                  win_r, win_nx, lose_r, lose_nx;
  logic                  busy_r, busy_nx, done_r, done_nx;
  logic                  wr_en_r, wr_en_nx;
  logic [2:0]            wr_row_r, wr_row_nx, wr_col_r, wr_col_nx;
  logic [1:0]            wr_color_r, wr_color_nx;
  logic                  all_green_s;

  assign all_green_s = (res_r == ALL_GREEN);

  // Next-state and next-output logic; new_game overrides every state.
  always_comb begin
    state_nx     = state_r;
    g_nx         = g_r;
    s_nx         = s_r;
    res_nx       = res_r;
    result_nx    = result_r;
    used_nx      = used_r;
    i_nx         = i_r;
    j_nx         = j_r;
    guess_num_nx = guess_num_r;
    win_nx       = win_r;
    lose_nx      = lose_r;
    busy_nx      = busy_r;
    done_nx      = 1'b0;
    wr_en_nx     = 1'b0;
    wr_row_nx    = wr_row_r;
    wr_col_nx    = wr_col_r;
    wr_color_nx  = wr_color_r;
    if (new_game) begin
      state_nx     = ST_IDLE;
      guess_num_nx = 3'd0;
      win_nx       = 1'b0;
      lose_nx      = 1'b0;
      busy_nx      = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_nx = 1'b0;
          if (start) begin
            g_nx     = guess;
            s_nx     = secret;
            res_nx   = '0;
            used_nx  = '0;
            i_nx     = 3'd0;
            j_nx     = 3'd0;
            busy_nx  = 1'b1;
            state_nx = ST_GREEN;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_GREEN: begin
          if (letter_at(g_r, i_r) == letter_at(s_r, i_r)) begin
            res_nx[2*int'(i_r) +: 2] = COL_GREEN;
            used_nx[i_r]             = 1'b1;
          end else begin
            res_nx[2*int'(i_r) +: 2] = COL_GRAY;
          end
          if (i_r == LAST) begin
            i_nx     = 3'd0;
            j_nx     = 3'd0;
            state_nx = ST_YELLOW;
          end else begin
            i_nx = i_r + 3'd1;
          end
        end
        ST_YELLOW: begin
          // A letter that is already coloured claims nothing, so only the lowest j wins.
          if ((color_at(res_r, i_r) == COL_GRAY) && !used_r[j_r] &&
              (letter_at(g_r, i_r) == letter_at(s_r, j_r))) begin
            res_nx[2*int'(i_r) +: 2] = COL_YELLOW;
            used_nx[j_r]             = 1'b1;
          end else begin
            res_nx = res_r;
          end
          if (j_r != LAST) begin
            j_nx = j_r + 3'd1;
          end else if (i_r != LAST) begin
            j_nx = 3'd0;
            i_nx = i_r + 3'd1;
          end else begin
            j_nx        = 3'd0;
            i_nx        = 3'd0;
            wr_en_nx    = 1'b1;
            wr_row_nx   = guess_num_r;
            wr_col_nx   = 3'd0;
            wr_color_nx = color_at(res_nx, 3'd0);
            state_nx    = ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (i_r == LAST) begin
            state_nx     = ST_DONE;
            done_nx      = 1'b1;
            result_nx    = res_r;
            guess_num_nx = guess_num_r + 3'd1;
            win_nx       = all_green_s;
            lose_nx      = !all_green_s && ((guess_num_r + 3'd1) == MAX_GN);
          end else begin
            i_nx        = i_r + 3'd1;
            wr_en_nx    = 1'b1;
            wr_col_nx   = i_r + 3'd1;
            wr_color_nx = color_at(res_r, i_r + 3'd1);
          end
        end
        ST_DONE: begin
          busy_nx  = 1'b0;
          state_nx = (win_r || lose_r) ? ST_OVER : ST_IDLE;
        end
        ST_OVER: begin
          busy_nx  = 1'b0;
          state_nx = ST_OVER;
        end
        default: begin
          busy_nx  = 1'b0;
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      g_r         <= '0;
      s_r         <= '0;
      res_r       <= '0;
      result_r    <= '0;
      used_r      <= '0;
      i_r         <= 3'd0;
      j_r         <= 3'd0;
      guess_num_r <= 3'd0;
      win_r       <= 1'b0;
      lose_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_row_r    <= 3'd0;
      wr_col_r    <= 3'd0;
      wr_color_r  <= 2'b00;
    end else begin
      state_r     <= state_nx;
      g_r         <= g_nx;
      s_r         <= s_nx;
      res_r       <= res_nx;
      result_r    <= result_nx;
      used_r      <= used_nx;
      i_r         <= i_nx;
      j_r         <= j_nx;
      guess_num_r <= guess_num_nx;
      win_r       <= win_nx;
      lose_r      <= lose_nx;
      busy_r      <= busy_nx;
      done_r      <= done_nx;
      wr_en_r     <= wr_en_nx;
      wr_row_r    <= wr_row_nx;
      wr_col_r    <= wr_col_nx;
      wr_color_r  <= wr_color_nx;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign guess_num = guess_num_r;
  assign win       = win_r;
  assign lose      = lose_r;
  assign wr_en     = wr_en_r;
  assign wr_row    = wr_row_r;
  assign wr_col    = wr_col_r;
  assign wr_color  = wr_color_r;

endmodule
